// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// The serial multiplier is expected to reuse the state encoding.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the arithmetic datapath of the serial blocks.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: operands stream LSB-first through one full_adder,
// carry registered between bits. Subtract is A + ~B + 1 with the +1 as initial carry.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, nstate;
  logic [WIDTH-1:0] opa, opb, res;
  logic             carry;
  logic [CW-1:0]    bitcnt;
  logic             fa_sum, fa_cout;
  logic             accept, last;

  assign accept = (state == S_IDLE) && start;
  assign last   = (state == S_SHIFT) && (bitcnt == LAST);

  full_adder u_cell (
    .A   (opa[0]),
    .B   (opb[0]),
    .Cin (carry),
    .Sum (fa_sum),
    .Cout(fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (start) nstate = S_SHIFT;
      S_SHIFT: if (last)  nstate = S_DONE;
      S_DONE:             nstate = S_IDLE;
      default:            nstate = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SHIFT) || (state == S_DONE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      bitcnt <= '0;
    end else if (accept) begin
      opa    <= A;
      opb    <= sub ? ~B : B;
      carry  <= sub;
      bitcnt <= '0;
    end else if (state == S_SHIFT) begin
      opa    <= opa >> 1;
      opb    <= opb >> 1;
      res    <= {fa_sum, res[WIDTH-1:1]};
      carry  <= fa_cout;
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // Results are written on the edge entering DONE. On that last bit the
  // registered carry is the carry into the MSB, so overflow needs no extra flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum      <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (last) begin
      Sum      <= {fa_sum, res[WIDTH-1:1]};
      Cout     <= fa_cout;
      overflow <= carry ^ fa_cout;
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: driver pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_serial_add_sub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, Cout, overflow;
  logic [W-1:0] Sum;

  int   total = 0, bad = 0, cyc = 0;
  exp_t exp_q[$];
  int   cap_q[$];
  logic [W-1:0] held = '0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic s);
    exp_t e;
    int   r, sr, sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      r      = int'(a) - int'(b);
      sr     = sa - sb;
      e.cout = (a >= b);
    end else begin
      r      = int'(a) + int'(b);
      sr     = sa + sb;
      e.cout = (r > 255);
    end
    e.sum = r[W-1:0];
    e.ovf = (sr > 127) || (sr < -128);
    return e;
  endfunction

  task automatic push(logic [W-1:0] a, logic [W-1:0] b, logic s);
    exp_q.push_back(model(a, b, s));
    cap_q.push_back(cyc + 1);
  endtask

  // Monitor: compares on done, otherwise checks that Sum holds.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          exp_t e;
          int   c;
          e = exp_q.pop_front();
          c = cap_q.pop_front();
          chk("sum", 32'(Sum), 32'(e.sum));
          chk("cout", 32'(Cout), 32'(e.cout));
          chk("overflow", 32'(overflow), 32'(e.ovf));
          chk("latency", 32'(cyc - c), 32'(W));
          held = e.sum;
        end
      end else begin
        chk("sum_hold", 32'(Sum), 32'(held));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
    end
  endtask

  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b, logic s);
    wait_idle();
    A = a; B = b; sub = s; start = 1'b1;
    push(a, b, s);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    sub = 1'($urandom);
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(Sum), 0);
    chk("rst_cout", 32'(Cout), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h25, 8'h17, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'h10, 8'h01, 1'b1);
    do_op(8'h00, 8'h01, 1'b1);
    do_op(8'h80, 8'h01, 1'b1);
    do_op(8'h80, 8'h80, 1'b0);

    // start during SHIFT must be ignored; an extra done would be unexpected
    do_op(8'h05, 8'h03, 1'b0);
    @(negedge clk);
    @(negedge clk);
    A = 8'hAA; B = 8'h11; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;

    // reset at bit-cycle 4 aborts the op
    do_op(8'h33, 8'h44, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(Sum), 0);
    chk("abort_cout", 32'(Cout), 0);
    exp_q.delete();
    cap_q.delete();
    held = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 1'b0);

    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom));

    // start held high: ops accepted every W+2 cycles, operands change every cycle
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < W + 2; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        A = W'($urandom);
        B = W'($urandom);
        sub = 1'($urandom);
        start = 1'b1;
        if (j == 0) push(A, B, sub);
      end
    end
    @(negedge clk);
    start = 1'b0;

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d pending ops expected 0", exp_q.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
